// File: rtl/bmult6x6_pkg.sv
// Shared definitions for the signed 6x6 radix-4 Booth multiplier slice.
//   COL_H      : bit height of each compressor input column, col0..col11
//   CONST_MASK : weight of the constant ones placed in the columns
//   booth_dig_t: one radix-4 Booth digit {one, two, neg}
package bmult6x6_pkg;

  localparam int COL_H [0:11] = '{2, 1, 3, 2, 4, 3, 4, 3, 2, 2, 1, 1};

  // Sign-extension correction: -(2^6 + 2^8 + 2^10) mod 2^12
  localparam logic [11:0] CONST_MASK = 12'hAC0;

  typedef struct packed {
    logic one;
    logic two;
    logic neg;
  } booth_dig_t;

endpackage

// File: rtl/bmult6x6_booth_enc.sv
// Combinational radix-4 Booth encoder for one digit.
//   a    : signed multiplicand
//   trip : multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   dig  : decoded digit {one, two, neg}
//   pp   : 7-bit partial product, magnitude XORed with neg
//          (the +1 of the two's complement is added as a column bit)
module bmult6x6_booth_enc
  import bmult6x6_pkg::*;
(
  input  logic signed [5:0] a,
  input  logic        [2:0] trip,
  output booth_dig_t        dig,
  output logic        [6:0] pp
);

  logic signed [6:0] a_x;
  logic signed [6:0] mag;

  always_comb begin
    dig.one = trip[1] ^ trip[0];
    dig.two = (trip[2] ^ trip[1]) & ~dig.one;
    dig.neg = trip[2] & ~(trip[1] & trip[0]);
    a_x     = {a[5], a};
    if (dig.one)      mag = a_x;
    else if (dig.two) mag = a_x <<< 1;
    else              mag = '0;
    pp = mag ^ {7{dig.neg}};
  end

endmodule

// File: rtl/bmult6x6_ppgen.sv
// Booth partial-product generator and result collector for the signed 6x6
// bit-heap multiplier. Drives the twelve compressor columns from a
// valid/ready operand port and collects comp_out into a credit-controlled
// show-ahead FIFO after the compressor latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_a/in_b signed operands
//   pp_col0..pp_col11   : registered column bits (zero when idle)
//   comp_out            : compressor sum, bits [11:0] used
//   res_valid/res_ready : result handshake, res_prod = (a*b) mod 2^12
//   pp_cnt              : accepted operand pairs, wrapping
module bmult6x6_ppgen
  import bmult6x6_pkg::*;
#(
  parameter int CMP_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [5:0] in_a,
  input  logic signed [5:0] in_b,
  output logic [1:0]        pp_col0,
  output logic [0:0]        pp_col1,
  output logic [2:0]        pp_col2,
  output logic [1:0]        pp_col3,
  output logic [3:0]        pp_col4,
  output logic [2:0]        pp_col5,
  output logic [3:0]        pp_col6,
  output logic [2:0]        pp_col7,
  output logic [1:0]        pp_col8,
  output logic [1:0]        pp_col9,
  output logic [0:0]        pp_col10,
  output logic [0:0]        pp_col11,
  input  logic [12:0]       comp_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [11:0]       res_prod,
  output logic [15:0]       pp_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < CMP_LAT + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least CMP_LAT+2");
  end

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  booth_dig_t  dig0, dig1, dig2;
  logic [6:0]  pp0, pp1, pp2;
  logic        accept, push, pop;
  logic [CNT_W-1:0] occ, fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [11:0] mem [FIFO_DEPTH];
  logic [CMP_LAT:0]   tag_p;
  logic [CMP_LAT+1:0] tag_shift;
  logic        unused_bits;

  // Only the neg flags leave the encoders; comp_out[12] is a carry we drop.
  assign unused_bits = ^{dig0.one, dig0.two, dig1.one, dig1.two,
                         dig2.one, dig2.two, comp_out[12]};

  bmult6x6_booth_enc u_enc0 (.a(in_a), .trip({in_b[1:0], 1'b0}), .dig(dig0), .pp(pp0));
  bmult6x6_booth_enc u_enc1 (.a(in_a), .trip(in_b[3:1]),          .dig(dig1), .pp(pp1));
  bmult6x6_booth_enc u_enc2 (.a(in_a), .trip(in_b[5:3]),          .dig(dig2), .pp(pp2));

  assign in_ready  = (occ < CNT_W'(FIFO_DEPTH)) && rst_n;
  assign accept    = in_valid && in_ready;
  assign push      = tag_p[CMP_LAT];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign res_prod  = res_valid ? mem[rd_ptr] : '0;
  assign tag_shift = {tag_p, accept};

  // Stage p0: column register; idle cycles present all-zero columns so the
  // compressor sees nothing, constants included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pp_col0, pp_col1, pp_col2, pp_col3, pp_col4, pp_col5,
       pp_col6, pp_col7, pp_col8, pp_col9, pp_col10, pp_col11} <= '0;
    end else if (accept) begin
      pp_col0  <= {dig0.neg, pp0[0]};
      pp_col1  <= pp0[1];
      pp_col2  <= {dig1.neg, pp1[0], pp0[2]};
      pp_col3  <= {pp1[1], pp0[3]};
      pp_col4  <= {dig2.neg, pp2[0], pp1[2], pp0[4]};
      pp_col5  <= {pp2[1], pp1[3], pp0[5]};
      pp_col6  <= {CONST_MASK[6], pp2[2], pp1[4], ~pp0[6]};
      pp_col7  <= {CONST_MASK[7], pp2[3], pp1[5]};
      pp_col8  <= {pp2[4], ~pp1[6]};
      pp_col9  <= {CONST_MASK[9], pp2[5]};
      pp_col10 <= ~pp2[6];
      pp_col11 <= CONST_MASK[11];
    end else begin
      {pp_col0, pp_col1, pp_col2, pp_col3, pp_col4, pp_col5,
       pp_col6, pp_col7, pp_col8, pp_col9, pp_col10, pp_col11} <= '0;
    end
  end

  // Tag pipeline p0..p(CMP_LAT): the last stage marks the edge at which
  // comp_out carries the result of the pair accepted CMP_LAT+1 edges ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_p <= '0;
    else        tag_p <= tag_shift[CMP_LAT:0];
  end

  // Credit counter, FIFO pointers and accept counter. Credits are taken at
  // accept, so every push has a free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pp_cnt   <= '0;
    end else begin
      if (accept && !pop)      occ <= occ + CNT_W'(1);
      else if (!accept && pop) occ <= occ - CNT_W'(1);
      if (push && !pop)        fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop)   fifo_cnt <= fifo_cnt - CNT_W'(1);
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);
      if (accept) pp_cnt <= pp_cnt + 16'd1;
    end
  end

  // FIFO storage holds data only; validity comes from fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= comp_out[11:0];
  end

endmodule

// File: tb/tb_bmult6x6_ppgen.sv
module tb_bmult6x6_ppgen;

  localparam int CMP_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [5:0] in_a, in_b;
  logic [1:0] pp_col0;  logic [0:0] pp_col1;  logic [2:0] pp_col2;
  logic [1:0] pp_col3;  logic [3:0] pp_col4;  logic [2:0] pp_col5;
  logic [3:0] pp_col6;  logic [2:0] pp_col7;  logic [1:0] pp_col8;
  logic [1:0] pp_col9;  logic [0:0] pp_col10; logic [0:0] pp_col11;
  logic [12:0] comp_out;
  logic        res_valid, res_ready;
  logic [11:0] res_prod;
  logic [15:0] pp_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int cyc      = 0;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bmult6x6_ppgen #(.CMP_LAT(CMP_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .pp_col0(pp_col0), .pp_col1(pp_col1), .pp_col2(pp_col2), .pp_col3(pp_col3),
    .pp_col4(pp_col4), .pp_col5(pp_col5), .pp_col6(pp_col6), .pp_col7(pp_col7),
    .pp_col8(pp_col8), .pp_col9(pp_col9), .pp_col10(pp_col10), .pp_col11(pp_col11),
    .comp_out(comp_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_prod(res_prod), .pp_cnt(pp_cnt)
  );

  // Bit-heap compressor stand-in: weighted population count of the columns,
  // delayed by CMP_LAT registers.
  logic [12:0] heap_sum;
  logic [12:0] cpipe [CMP_LAT];
  always_comb begin
    int s;
    s = $countones(pp_col0)        + ($countones(pp_col1)  << 1)
      + ($countones(pp_col2) << 2) + ($countones(pp_col3)  << 3)
      + ($countones(pp_col4) << 4) + ($countones(pp_col5)  << 5)
      + ($countones(pp_col6) << 6) + ($countones(pp_col7)  << 7)
      + ($countones(pp_col8) << 8) + ($countones(pp_col9)  << 9)
      + ($countones(pp_col10) << 10) + ($countones(pp_col11) << 11);
    heap_sum = 13'(s);
  end
  always @(posedge clk) begin
    cpipe[0] <= heap_sum;
    for (int k = 1; k < CMP_LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign comp_out = cpipe[CMP_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected product queued on accept, checked on pop.
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      exp_q.push_back(12'((int'(in_a) * int'(in_b)) & 32'hFFF));
      acc_cnt++;
    end
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {20'd0, res_prod}, 32'hFFFF_FFFF);
      else                   chk("res_prod", {20'd0, res_prod}, {20'd0, exp_q.pop_front()});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge with
  // in_valid still high.
  task automatic send(input logic signed [5:0] a, input logic signed [5:0] b);
    int w = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      w++;
      if (w > 200) begin chk("send_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 || res_valid) begin
      w++;
      if (w > 100) begin chk("drain_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic directed(input logic signed [5:0] a, input logic signed [5:0] b,
                          input logic [11:0] exp, input string name);
    int w = 0;
    send(a, b);
    in_valid = 1'b0;
    while (!res_valid && w < 10) begin @(posedge clk); #1; w++; end
    chk(name, {20'd0, res_prod}, {20'd0, exp});
    wait_drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_prod", res_prod, 0);
    chk("rst_pp_cnt", pp_cnt, 0);
    chk("rst_col6", pp_col6, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    res_ready = 1'b1;

    // Latency: result visible after the second edge following accept.
    send(6'sd3, 6'sd5);
    in_valid = 1'b0;
    chk("lat_e0_valid", res_valid, 0);
    @(posedge clk); #1;
    chk("lat_e1_valid", res_valid, 0);
    @(posedge clk); #1;
    chk("lat_e2_valid", res_valid, 1);
    chk("lat_e2_prod", res_prod, 12'h00F);
    wait_drain();

    directed(-6'sd32, -6'sd32, 12'h400, "m32_m32");
    directed(-6'sd32,  6'sd31, 12'hC20, "m32_31");
    directed( 6'sd31, -6'sd1,  12'hFE1, "31_m1");

    // Zero operands: only the sign-extension constants and ~s bits remain.
    send(6'sd0, 6'sd0);
    in_valid = 1'b0;
    chk("z_col0", pp_col0, 0);  chk("z_col2", pp_col2, 0);
    chk("z_col4", pp_col4, 0);  chk("z_col5", pp_col5, 0);
    chk("z_col6", pp_col6, 4'b1001); chk("z_col7", pp_col7, 3'b100);
    chk("z_col8", pp_col8, 2'b01);   chk("z_col9", pp_col9, 2'b10);
    chk("z_col10", pp_col10, 1);     chk("z_col11", pp_col11, 1);
    @(posedge clk); #1;
    chk("idle_col6", pp_col6, 0);
    chk("idle_col11", pp_col11, 0);
    @(posedge clk); #1;
    chk("z_prod", res_prod, 0);
    wait_drain();

    // Backpressure: five offers against a stalled result port.
    res_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 6'($urandom); in_b = 6'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc_cnt - base, 4);
    chk("bp_in_ready_full", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_res_valid", res_valid, 1);
    res_ready = 1'b1;
    chk("bp_ready_same_cycle", in_ready, 0);
    @(posedge clk); #1;
    chk("bp_ready_after_pop", in_ready, 1);
    wait_drain();

    // Back-to-back random stream with no stall.
    c0 = cyc;
    for (int i = 0; i < 1000; i++) send(6'($urandom), 6'($urandom));
    in_valid = 1'b0;
    chk("b2b_cycles", cyc - c0, 1000);
    wait_drain();

    // Reset in the cycle after an accept discards the in-flight result.
    send(6'sd7, 6'sd9);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_col6", pp_col6, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_res_valid", res_valid, 0);
    end
    chk("mid_rst_pp_cnt", pp_cnt, 0);

    // Counter wrap: 65537 accepts from zero.
    for (int i = 0; i < 65537; i++) send(6'($urandom), 6'($urandom));
    in_valid = 1'b0;
    chk("pp_cnt_wrap", pp_cnt, 1);
    wait_drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
